// File: rtl/adder_seq_multiplier_pkg.sv
// Shared definitions for the shift-add multiplier.
// State encoding and the iteration counter width helper.
package adder_seq_multiplier_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int count_width(input int xlen);
        return $clog2(xlen + 1);
    endfunction

endpackage

// File: rtl/adder_seq_multiplier_rca.sv
// Plain ripple-carry adder, one full adder per bit.
// Shared by the multiplier for every partial-product accumulation.
module ripple_carry_adder #(
    parameter int xlen = 8
) (
    input  logic [xlen-1:0] a_i,
    input  logic [xlen-1:0] b_i,
    input  logic            carry_i,
    output logic [xlen-1:0] sum_o,
    output logic            carry_o
);

    always_comb begin
        logic cy;
        cy    = carry_i;
        sum_o = '0;
        for (int i = 0; i < xlen; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ cy;
            cy       = (a_i[i] & b_i[i]) | (cy & (a_i[i] ^ b_i[i]));
        end
        carry_o = cy;
    end

endmodule

// File: rtl/adder_seq_multiplier.sv
// Multi-cycle unsigned shift-add multiplier, one adder reused xlen times.
// Operand and result sides use valid/ready handshakes.
module adder_seq_multiplier
    import adder_seq_multiplier_pkg::*;
#(
    parameter int xlen = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [xlen-1:0]   a,
    input  logic [xlen-1:0]   b,
    output logic [2*xlen-1:0] result,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              busy
);

    localparam int CW = count_width(xlen);

    state_e              state_q, state_d;
    logic [xlen-1:0]     mcand_q, mcand_d;
    logic [2*xlen-1:0]   prod_q, prod_d;
    logic [CW-1:0]       count_q, count_d;
    logic [2*xlen-1:0]   result_q, result_d;
    logic                valid_q, valid_d;

    logic [xlen-1:0]     add_sum;
    logic                add_cout;

    ripple_carry_adder #(.xlen(xlen)) u_rca (
        .a_i     (prod_q[2*xlen-1:xlen]),
        .b_i     (mcand_q & {xlen{prod_q[0]}}),
        .carry_i (1'b0),
        .sum_o   (add_sum),
        .carry_o (add_cout)
    );

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        count_d  = count_q;
        result_d = result_q;
        valid_d  = valid_q;
        case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    mcand_d = a;
                    prod_d  = {{xlen{1'b0}}, b};
                    count_d = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                prod_d  = {add_cout, add_sum, prod_q[xlen-1:1]};
                count_d = count_q + CW'(1);
                if (count_q == CW'(xlen - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // First DONE cycle latches the product; valid follows an edge later.
                if (valid_q && result_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end else if (!valid_q) begin
                    valid_d  = 1'b1;
                    result_d = prod_q;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mcand_q  <= '0;
            prod_q   <= '0;
            count_q  <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            count_q  <= count_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign start_ready  = (state_q == ST_IDLE);
    assign busy         = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign result       = result_q;
    assign result_valid = valid_q;

endmodule
